// File: rtl/ppu_pixel_pipe.sv
// ppu_pixel_pipe: BG pixel FIFO plus 8-slot sprite FIFO for PPU draw mode.
// Pops one pixel per cycle, discards SCX fine-scroll pixels, mixes BG and
// sprite by priority/transparency, maps through BGP/OBP0/OBP1 and flags the
// end of the visible line.
//
// state | meaning
// IDLE  | no scanline in progress, nothing pops
// RUN   | popping: first scx_fine pops discarded, then pixels emitted
// DONE  | last visible pixel emitted, FIFO contents held until line_start
module ppu_pixel_pipe #(
  parameter int BG_DEPTH = 16,
  parameter int LINE_PX  = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic [2:0] scx_fine,
  input  logic       bg_en,
  input  logic       sp_en,
  input  logic [7:0] bgp,
  input  logic [7:0] obp0,
  input  logic [7:0] obp1,
  input  logic [7:0] bg_lo,
  input  logic [7:0] bg_hi,
  input  logic       bg_push,
  output logic       bg_ready,
  input  logic [7:0] sp_lo,
  input  logic [7:0] sp_hi,
  input  logic [7:0] sp_attr,
  input  logic       sp_push,
  input  logic       stall,
  output logic [1:0] px_out,
  output logic       px_valid,
  output logic [7:0] px_x,
  output logic       line_done,
  output logic       overflow
);

  localparam int PW = $clog2(BG_DEPTH);
  localparam int CW = $clog2(BG_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;

  // BG FIFO storage: circular buffer of 2-bit colours
  logic [1:0]    bg_mem [BG_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] bg_cnt;

  // Sprite slot layout: {colour[1:0], prio, pal}; slot 0 sits at the BG head
  logic [3:0]    sp_slot   [8];
  logic [3:0]    sp_merged [8];

  logic [2:0]    discard;
  logic [7:0]    x_cnt;

  logic          push_ok;
  logic          push_drop;
  logic          do_pop;
  logic [CW-1:0] push_inc;
  logic [CW-1:0] pop_dec;

  logic [1:0]    bg_head;
  logic [1:0]    bc;
  logic [1:0]    sc;
  logic          sp_prio;
  logic          sp_pal;
  logic          sp_win;
  logic [1:0]    mix_col;
  logic [7:0]    mix_pal;
  logic [1:0]    shade;

  // Attribute bits that have no function in the mixer
  logic          unused_attr;
  assign unused_attr = ^{sp_attr[6], sp_attr[3:0]};

  // Circular pointer advance that also works for non-power-of-two depths
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= BG_DEPTH) s = s - BG_DEPTH;
    return PW'(s);
  endfunction

  // Free-slot test uses only the registered count
  assign bg_ready = ((CW'(BG_DEPTH) - bg_cnt) >= CW'(8));

  // Push acceptance and pop qualification; line_start overrides everything
  always_comb begin
    push_ok   = bg_push && bg_ready && !line_start;
    push_drop = bg_push && !bg_ready && !line_start;
    do_pop    = (state == S_RUN) && (bg_cnt != '0) && !stall && !sp_push && !line_start;
    push_inc  = push_ok ? CW'(8) : '0;
    pop_dec   = CW'(do_pop);
  end

  // Priority/transparency mix of the FIFO heads and palette lookup
  always_comb begin
    bg_head = bg_mem[rd_ptr];
    bc      = bg_en ? bg_head : 2'd0;
    sc      = sp_slot[0][3:2];
    sp_prio = sp_slot[0][1];
    sp_pal  = sp_slot[0][0];
    sp_win  = sp_en && (sc != 2'd0) && !(sp_prio && (bc != 2'd0));
    mix_col = sp_win ? sc : bc;
    mix_pal = bgp;
    if (sp_win) mix_pal = sp_pal ? obp1 : obp0;
    case (mix_col)
      2'd0:    shade = mix_pal[1:0];
      2'd1:    shade = mix_pal[3:2];
      2'd2:    shade = mix_pal[5:4];
      default: shade = mix_pal[7:6];
    endcase
  end

  // Sprite row merge: only transparent slots accept, only opaque pixels write
  always_comb begin
    logic [1:0] row_col;
    row_col = 2'd0;
    for (int i = 0; i < 8; i++) begin
      if (sp_attr[5]) row_col = {sp_hi[i], sp_lo[i]};
      else            row_col = {sp_hi[7-i], sp_lo[7-i]};
      sp_merged[i] = sp_slot[i];
      if ((sp_slot[i][3:2] == 2'd0) && (row_col != 2'd0))
        sp_merged[i] = {row_col, sp_attr[7], sp_attr[4]};
    end
  end

  // BG FIFO write port: 8 pixels, leftmost (bit 7) first
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < 8; i++)
        bg_mem[ptr_add(wr_ptr, i)] <= {bg_hi[7-i], bg_lo[7-i]};
    end
  end

  // Line FSM, FIFO bookkeeping and registered pixel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      bg_cnt    <= '0;
      for (int i = 0; i < 8; i++) sp_slot[i] <= 4'd0;
      discard   <= 3'd0;
      x_cnt     <= 8'd0;
      px_out    <= 2'd0;
      px_valid  <= 1'b0;
      px_x      <= 8'd0;
      line_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      px_valid  <= 1'b0;
      line_done <= 1'b0;
      if (line_start) begin
        state    <= S_RUN;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        bg_cnt   <= '0;
        for (int i = 0; i < 8; i++) sp_slot[i] <= 4'd0;
        discard  <= scx_fine;
        x_cnt    <= 8'd0;
        px_x     <= 8'd0;
        overflow <= 1'b0;
      end else begin
        if (push_drop) overflow <= 1'b1;
        if (push_ok)   wr_ptr   <= ptr_add(wr_ptr, 8);
        if (do_pop)    rd_ptr   <= ptr_add(rd_ptr, 1);
        bg_cnt <= bg_cnt + push_inc - pop_dec;

        if (sp_push) begin
          for (int i = 0; i < 8; i++) sp_slot[i] <= sp_merged[i];
        end else if (do_pop) begin
          for (int i = 0; i < 7; i++) sp_slot[i] <= sp_slot[i+1];
          sp_slot[7] <= 4'd0;
        end

        if (do_pop) begin
          if (discard != 3'd0) begin
            discard <= discard - 3'd1;
          end else begin
            px_valid <= 1'b1;
            px_out   <= shade;
            px_x     <= x_cnt;
            x_cnt    <= x_cnt + 8'd1;
            if (x_cnt == 8'(LINE_PX - 1)) begin
              line_done <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_pixel_pipe.sv
// tb_ppu_pixel_pipe: directed vectors, corner sequences and randomized
// traffic for ppu_pixel_pipe, checked against a queue-based reference model.
module tb_ppu_pixel_pipe;

  localparam int BG_DEPTH = 16;
  localparam int LINE_PX  = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_start;
  logic [2:0] scx_fine;
  logic       bg_en, sp_en;
  logic [7:0] bgp, obp0, obp1;
  logic [7:0] bg_lo, bg_hi;
  logic       bg_push;
  logic       bg_ready;
  logic [7:0] sp_lo, sp_hi, sp_attr;
  logic       sp_push;
  logic       stall;
  logic [1:0] px_out;
  logic       px_valid;
  logic [7:0] px_x;
  logic       line_done;
  logic       overflow;

  ppu_pixel_pipe #(.BG_DEPTH(BG_DEPTH), .LINE_PX(LINE_PX)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .scx_fine(scx_fine),
    .bg_en(bg_en), .sp_en(sp_en), .bgp(bgp), .obp0(obp0), .obp1(obp1),
    .bg_lo(bg_lo), .bg_hi(bg_hi), .bg_push(bg_push), .bg_ready(bg_ready),
    .sp_lo(sp_lo), .sp_hi(sp_hi), .sp_attr(sp_attr), .sp_push(sp_push),
    .stall(stall), .px_out(px_out), .px_valid(px_valid), .px_x(px_x),
    .line_done(line_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  logic [1:0] q_bg [$];
  logic [1:0] m_spc [8];
  logic       m_spp [8];
  logic       m_spl [8];
  int         m_state;   // 0 idle, 1 running, 2 line finished
  int         m_disc;
  int         m_x;
  bit         m_ovf;
  bit         e_valid, e_done, e_ovf, e_ready;
  logic [1:0] e_out;
  logic [7:0] e_x;

  typedef struct {
    logic       bg_en;
    logic       sp_en;
    logic [1:0] bgc;
    logic [1:0] spc;
    logic       prio;
    logic       pal;
    logic [1:0] exp_shade;
  } mix_vec_t;

  mix_vec_t mv [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_sprites();
    for (int i = 0; i < 8; i++) begin
      m_spc[i] = 2'd0; m_spp[i] = 1'b0; m_spl[i] = 1'b0;
    end
  endtask

  // Computes what the outputs must be after the coming clock edge
  task automatic model_cycle();
    int         free_slots;
    int         src;
    bit         pop, win;
    logic [1:0] head, c, bc, sc, col, shade;
    logic [7:0] pal;
    e_done  = 1'b0;
    e_valid = 1'b0;
    if (rst) begin
      q_bg.delete(); clear_sprites();
      m_state = 0; m_disc = 0; m_x = 0; m_ovf = 1'b0;
      e_out = 2'd0; e_x = 8'd0;
    end else if (line_start) begin
      q_bg.delete(); clear_sprites();
      m_state = 1; m_disc = int'(scx_fine); m_x = 0; m_ovf = 1'b0;
      e_x = 8'd0;
    end else begin
      free_slots = BG_DEPTH - q_bg.size();
      pop  = (m_state == 1) && (q_bg.size() > 0) && !stall && !sp_push;
      head = 2'd0;
      if (pop) head = q_bg.pop_front();
      if (bg_push) begin
        if (free_slots >= 8) begin
          for (int i = 0; i < 8; i++) q_bg.push_back({bg_hi[7-i], bg_lo[7-i]});
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (sp_push) begin
        for (int i = 0; i < 8; i++) begin
          src = sp_attr[5] ? 7 - i : i;
          c = {sp_hi[7-src], sp_lo[7-src]};
          if (m_spc[i] == 2'd0 && c != 2'd0) begin
            m_spc[i] = c; m_spp[i] = sp_attr[7]; m_spl[i] = sp_attr[4];
          end
        end
      end else if (pop) begin
        bc    = bg_en ? head : 2'd0;
        sc    = m_spc[0];
        win   = sp_en && (sc != 2'd0) && !(m_spp[0] && bc != 2'd0);
        col   = win ? sc : bc;
        pal   = !win ? bgp : (m_spl[0] ? obp1 : obp0);
        shade = 2'((pal >> (2 * int'(col))) & 8'd3);
        for (int i = 0; i < 7; i++) begin
          m_spc[i] = m_spc[i+1]; m_spp[i] = m_spp[i+1]; m_spl[i] = m_spl[i+1];
        end
        m_spc[7] = 2'd0; m_spp[7] = 1'b0; m_spl[7] = 1'b0;
        if (m_disc > 0) begin
          m_disc--;
        end else begin
          e_valid = 1'b1;
          e_out   = shade;
          e_x     = 8'(m_x);
          if (m_x == LINE_PX - 1) begin
            e_done  = 1'b1;
            m_state = 2;
          end
          m_x++;
        end
      end
    end
    e_ovf   = m_ovf;
    e_ready = (BG_DEPTH - q_bg.size()) >= 8;
  endtask

  // One clock: model prediction, edge, then compare 1 time unit later
  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    chk("px_valid", 32'(px_valid), 32'(e_valid));
    chk("line_done", 32'(line_done), 32'(e_done));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("bg_ready", 32'(bg_ready), 32'(e_ready));
    if (e_valid) begin
      chk("px_out", 32'(px_out), 32'(e_out));
      chk("px_x", 32'(px_x), 32'(e_x));
    end
  endtask

  task automatic do_line_start(input logic [2:0] scx);
    line_start = 1'b1; scx_fine = scx;
    step();
    line_start = 1'b0;
  endtask

  task automatic push_bg(input logic [7:0] lo, input logic [7:0] hi);
    bg_lo = lo; bg_hi = hi; bg_push = 1'b1;
    step();
    bg_push = 1'b0;
  endtask

  task automatic push_sp(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] attr);
    sp_lo = lo; sp_hi = hi; sp_attr = attr; sp_push = 1'b1;
    step();
    sp_push = 1'b0;
  endtask

  logic [1:0] exp_a [8];
  logic [1:0] exp_c [8];
  int n_valid, n_done, done_x, first_k, first_x, got, guard;

  initial begin
    mv[0] = '{1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 2'd1};
    mv[1] = '{1'b1, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 2'd3};
    mv[2] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 2'd3};
    mv[3] = '{1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 2'd3};
    mv[4] = '{1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 2'd0};
    mv[5] = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 2'd0};
    mv[6] = '{1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 1'b1, 2'd1};
    mv[7] = '{1'b1, 1'b1, 2'd3, 2'd1, 1'b1, 1'b0, 2'd2};
    exp_a = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3};
    exp_c = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};

    rst = 1'b1; line_start = 1'b0; scx_fine = 3'd0; bg_en = 1'b1; sp_en = 1'b1;
    bgp = 8'hE4; obp0 = 8'hE4; obp1 = 8'hE4; bg_lo = 8'h00; bg_hi = 8'h00;
    bg_push = 1'b0; sp_lo = 8'h00; sp_hi = 8'h00; sp_attr = 8'h00;
    sp_push = 1'b0; stall = 1'b0;

    // Reset values
    step(); step();
    chk("rst_px_out", 32'(px_out), 32'd0);
    chk("rst_px_valid", 32'(px_valid), 32'd0);
    chk("rst_px_x", 32'(px_x), 32'd0);
    chk("rst_line_done", 32'(line_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_bg_ready", 32'(bg_ready), 32'd1);
    rst = 1'b0;
    step();
    chk("idle_no_px", 32'(px_valid), 32'd0);

    // Basic row: colours 0,0,2,2,1,1,3,3 through identity palette
    do_line_start(3'd0);
    push_bg(8'h0F, 8'h33);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("row_valid", 32'(px_valid), 32'd1);
      chk("row_shade", 32'(px_out), 32'(exp_a[i]));
      chk("row_x", 32'(px_x), 32'(i));
    end
    step();
    chk("row_empty", 32'(px_valid), 32'd0);

    // Fine scroll of 3 over two rows
    do_line_start(3'd3);
    n_valid = 0; first_k = -1; first_x = -1;
    for (int k = 0; k < 26; k++) begin
      if (k < 2) begin bg_lo = 8'hFF; bg_hi = 8'h00; bg_push = 1'b1; end
      step();
      bg_push = 1'b0;
      if (px_valid) begin
        if (first_k < 0) begin first_k = k; first_x = int'(px_x); end
        n_valid++;
      end
    end
    chk("scx_first_step", 32'(first_k), 32'd4);
    chk("scx_first_x", 32'(first_x), 32'd0);
    chk("scx_valid_count", 32'(n_valid), 32'd13);

    // Two overlapping sprite rows, with a stall in the middle of output
    do_line_start(3'd0);
    push_bg(8'h00, 8'h00);
    push_sp(8'hF0, 8'h00, 8'h00);
    push_sp(8'hFF, 8'hFF, 8'h20);
    got = 0;
    for (int k = 0; k < 14; k++) begin
      stall = (k >= 2 && k < 5);
      step();
      if (stall) chk("stall_no_px", 32'(px_valid), 32'd0);
      if (px_valid) begin
        if (got < 8) begin
          chk("sprite_shade", 32'(px_out), 32'(exp_c[got]));
          chk("sprite_x", 32'(px_x), 32'(got));
        end
        got++;
      end
    end
    stall = 1'b0;
    chk("sprite_px_count", 32'(got), 32'd8);

    // Mixing table
    bgp = 8'h9C; obp0 = 8'h1B; obp1 = 8'h4E;
    for (int v = 0; v < 8; v++) begin
      bg_en = mv[v].bg_en; sp_en = mv[v].sp_en;
      do_line_start(3'd0);
      push_bg({8{mv[v].bgc[0]}}, {8{mv[v].bgc[1]}});
      push_sp({8{mv[v].spc[0]}}, {8{mv[v].spc[1]}},
              {mv[v].prio, 2'b00, mv[v].pal, 4'b0000});
      step();
      chk("mix_valid", 32'(px_valid), 32'd1);
      chk($sformatf("mix_vec%0d", v), 32'(px_out), 32'(mv[v].exp_shade));
    end
    bg_en = 1'b1; sp_en = 1'b1;

    // Continuous feed over a full line
    do_line_start(3'd0);
    n_valid = 0; n_done = 0; done_x = -1;
    for (int k = 0; k < 400; k++) begin
      bg_push = bg_ready; bg_lo = 8'($urandom); bg_hi = 8'($urandom);
      step();
      if (px_valid) n_valid++;
      if (line_done) begin n_done++; done_x = int'(px_x); end
    end
    bg_push = 1'b0;
    chk("line_valid_count", 32'(n_valid), 32'(LINE_PX));
    chk("line_done_count", 32'(n_done), 32'd1);
    chk("line_done_x", 32'(done_x), 32'(LINE_PX - 1));

    // Dropped push at count = BG_DEPTH-7
    do_line_start(3'd0);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bg_push = bg_ready; bg_lo = 8'($urandom); bg_hi = 8'($urandom);
      step();
    end
    bg_push = 1'b0; stall = 1'b0; guard = 0;
    while (q_bg.size() > BG_DEPTH - 7 && guard < 40) begin
      step(); guard++;
    end
    stall = 1'b1;
    chk("pre_ovf_ready", 32'(bg_ready), 32'd0);
    push_bg(8'hAA, 8'h55);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_ready", 32'(bg_ready), 32'd0);
    stall = 1'b0; n_valid = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (px_valid) n_valid++;
    end
    chk("ovf_count_kept", 32'(n_valid), 32'(BG_DEPTH - 7));
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_line_start(3'd0);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Reset in the middle of a line, with overflow raised
    push_bg(8'h12, 8'h34);
    push_bg(8'h56, 8'h78);
    push_bg(8'h9A, 8'hBC);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(px_valid), 32'd0);
    chk("mid_rst_x", 32'(px_x), 32'd0);
    chk("mid_rst_out", 32'(px_out), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_ready", 32'(bg_ready), 32'd1);
    rst = 1'b0;
    push_bg(8'hFF, 8'hFF);
    step();
    chk("post_rst_idle", 32'(px_valid), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      line_start = ((m_state != 1) && ($urandom_range(0, 9) == 0)) ||
                   ($urandom_range(0, 499) == 0);
      if (line_start) begin
        scx_fine = 3'($urandom);
        bgp = 8'($urandom); obp0 = 8'($urandom); obp1 = 8'($urandom);
        bg_en = ($urandom_range(0, 3) != 0);
        sp_en = ($urandom_range(0, 3) != 0);
      end
      bg_push = bg_ready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      bg_lo = 8'($urandom); bg_hi = 8'($urandom);
      sp_push = ($urandom_range(0, 9) == 0);
      sp_lo = 8'($urandom); sp_hi = 8'($urandom); sp_attr = 8'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
